// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: EX op codes, engine
// calc codes and controller state encodings.
package muldiv_ctrl_pkg;

    // HI/LO-class op codes presented by the EX stage; 3'd6/3'd7 are no-ops
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Calculator engine operation select
    typedef logic [1:0] cal_t;
    localparam cal_t CAL_MULT  = 2'd0;
    localparam cal_t CAL_MULTU = 2'd1;
    localparam cal_t CAL_DIV   = 2'd2;
    localparam cal_t CAL_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle between the sequencer (master) and the multiply/divide engine (slave).
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic        ena;     // held high for the whole operation
    cal_t        calc;
    logic [31:0] a;
    logic [31:0] b;
    logic        finish;  // level, stays high until ena drops
    logic [31:0] hi;      // remainder / high product
    logic [31:0] lo;      // quotient / low product

    modport master (output ena, calc, a, b, input finish, hi, lo);
    modport slave  (input ena, calc, a, b, output finish, hi, lo);

endinterface

// File: rtl/muldiv_wait_timer.sv
// Cycle counter bounding how long the sequencer waits for the engine.
// expired is high while the count equals TIMEOUT_CYCLES-1.
module muldiv_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // Count up while enabled; clear has priority over enable
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between EX and the multiply/divide engine. Owns architectural
// HI/LO, drives the engine for the whole operation and stalls the pipeline
// while busy. Optional macro MDU_DIVZERO_BYPASS_EN: divide by zero completes
// in IDLE without using the engine.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  logic [2:0]          op,
    input  logic [31:0]         rs_data,
    input  logic [31:0]         rt_data,
    input  logic                mf_req,
    input  logic                flush,
    muldiv_ctrl_if.master       eng,
    output logic [31:0]         hi,
    output logic [31:0]         lo,
    output logic                op_ready,
    output logic                stall,
    output logic                done,
    output logic                timeout_err
);

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    cal_t        calc_q;
    logic [31:0] a_q, b_q;
    logic        done_q, done_d;
    logic        tmo_q, tmo_d;
    logic        latch_op;
    logic        busy_ena;
    logic        tmr_clear, tmr_enable, tmr_expired;
    cal_t        op_cal;

    muldiv_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // Map the accepted op to the engine's calc code
    always_comb begin
        case (op)
            OP_MULTU: op_cal = CAL_MULTU;
            OP_DIV:   op_cal = CAL_DIV;
            OP_DIVU:  op_cal = CAL_DIVU;
            default:  op_cal = CAL_MULT;
        endcase
    end

    // Next-state, HI/LO writeback and handshake outputs
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        tmo_d      = 1'b0;
        latch_op   = 1'b0;
        op_ready   = 1'b0;
        busy_ena   = 1'b0;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;

        unique case (state_q)
            StIdle: begin
                op_ready = 1'b1;
                // flush outranks a presented op: nothing is accepted
                if (op_valid && !flush) begin
                    case (op)
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
`ifdef MDU_DIVZERO_BYPASS_EN
                            if (is_div(op) && (rt_data == '0)) begin
                                hi_d   = rs_data;
                                lo_d   = '1;
                                done_d = 1'b1;
                            end else begin
                                latch_op = 1'b1;
                                state_d  = StIssue;
                            end
`else
                            latch_op = 1'b1;
                            state_d  = StIssue;
`endif
                        end
                        default: ;  // unknown op accepted as a no-op
                    endcase
                end
            end
            StIssue: begin
                busy_ena  = 1'b1;
                tmr_clear = 1'b1;
                state_d   = flush ? StDrain : StWait;
            end
            StWait: begin
                busy_ena   = 1'b1;
                tmr_enable = 1'b1;
                // Priority: flush, then finish, then timeout
                if (flush) begin
                    state_d = StDrain;
                end else if (eng.finish) begin
                    hi_d    = eng.hi;
                    lo_d    = eng.lo;
                    done_d  = 1'b1;
                    state_d = StDrain;
                end else if (tmr_expired) begin
                    tmo_d   = 1'b1;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // ena low for one cycle so the engine re-arms its edges
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, HI/LO and latched operand registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            calc_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            if (latch_op) begin
                calc_q <= op_cal;
                a_q    <= rs_data;
                b_q    <= rt_data;
            end
        end
    end

    assign eng.ena     = busy_ena;
    assign eng.calc    = calc_q;
    assign eng.a       = a_q;
    assign eng.b       = b_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign done        = done_q;
    assign timeout_err = tmo_q;
    assign stall       = (op_valid && !op_ready) || (mf_req && (state_q != StIdle));

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a stub engine and a HI/LO scoreboard.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        mf_req, flush;
    logic [31:0] hi, lo;
    logic        op_ready, stall, done, timeout_err;

    int tests = 0;
    int fails = 0;
    logic [63:0] sb[$];

    muldiv_ctrl_if eng_bus ();

    muldiv_ctrl #(
        .TIMEOUT_CYCLES (64),
        .CNT_W          (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .mf_req      (mf_req),
        .flush       (flush),
        .eng         (eng_bus.master),
        .hi          (hi),
        .lo          (lo),
        .op_ready    (op_ready),
        .stall       (stall),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub engine: finish rises fin_delay cycles after ena (never if < 0)
    int fin_delay = -1;
    int ecnt = 0;
    logic signed [63:0] sprod;
    logic        [63:0] uprod;

    always @(posedge clk) begin
        if (eng_bus.ena !== 1'b1) ecnt <= 0;
        else ecnt <= ecnt + 1;
    end

    assign eng_bus.finish = (eng_bus.ena === 1'b1) && (fin_delay >= 0) && (ecnt >= fin_delay);

    always_comb begin
        sprod = $signed({{32{eng_bus.a[31]}}, eng_bus.a}) * $signed({{32{eng_bus.b[31]}}, eng_bus.b});
        uprod = {32'h0, eng_bus.a} * {32'h0, eng_bus.b};
        eng_bus.hi = '0;
        eng_bus.lo = '0;
        case (eng_bus.calc)
            CAL_MULT:  {eng_bus.hi, eng_bus.lo} = sprod;
            CAL_MULTU: {eng_bus.hi, eng_bus.lo} = uprod;
            default: begin
                if (eng_bus.b == 32'h0) begin
                    eng_bus.hi = eng_bus.a;
                    eng_bus.lo = 32'hFFFF_FFFF;
                end else if (eng_bus.calc == CAL_DIVU) begin
                    eng_bus.lo = eng_bus.a / eng_bus.b;
                    eng_bus.hi = eng_bus.a % eng_bus.b;
                end else begin
                    eng_bus.lo = $signed(eng_bus.a) / $signed(eng_bus.b);
                    eng_bus.hi = $signed(eng_bus.a) % $signed(eng_bus.b);
                end
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued HI/LO result
    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_done: got done=1 expected no done (hi=%h lo=%h)", hi, lo);
            end
            if (sb.size() > 0) begin
                logic [63:0] exp;
                exp = sb.pop_front();
                check("done_hi", hi, exp[63:32]);
                check("done_lo", lo, exp[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run until op_ready returns, tallying stall mismatches and done pulses
    task automatic run_busy(input logic exp_stall, output int busy, output int stall_bad,
                            output int dn);
        busy = 0;
        stall_bad = 0;
        dn = 0;
        while (op_ready !== 1'b1 && busy < 300) begin
            @(negedge clk);
            if (stall !== exp_stall) stall_bad++;
            if (done === 1'b1) dn++;
            busy++;
            tick();
        end
    endtask

    task automatic present(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op = o;
        rs_data = a;
        rt_data = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy, sbad, dn, n, bad, rose;
        reset = 1'b1;
        op_valid = 1'b0;
        op = 3'd0;
        rs_data = '0;
        rt_data = '0;
        mf_req = 1'b0;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_ena", eng_bus.ena, 32'h0);
        check("rst_calc", eng_bus.calc, 32'h0);
        check("rst_a", eng_bus.a, 32'h0);
        check("rst_done", done, 32'h0);
        check("rst_tmo", timeout_err, 32'h0);
        check("rst_ready", op_ready, 32'h1);

        // MULT -3 * 5, finish 10 cycles after ena, mf_req held
        fin_delay = 10;
        sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
        mf_req = 1'b1;
        present(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        @(negedge clk);
        check("t1_ready", op_ready, 32'h1);
        check("t1_stall_idle", stall, 32'h0);
        tick();
        op_valid = 1'b0;
        check("t1_ena", eng_bus.ena, 32'h1);
        check("t1_calc", eng_bus.calc, CAL_MULT);
        check("t1_a", eng_bus.a, 32'hFFFF_FFFD);
        check("t1_b", eng_bus.b, 32'd5);
        run_busy(1'b1, busy, sbad, dn);
        check("t1_busy_cycles", busy, 32'd12);
        check("t1_stall_bad", sbad, 32'd0);
        check("t1_done_pulses", dn, 32'd1);
        check("t1_hi", hi, 32'hFFFF_FFFF);
        check("t1_lo", lo, 32'hFFFF_FFF1);
        mf_req = 1'b0;

        // DIVU 100/7 then MTHI offered during the operation
        fin_delay = 4;
        sb.push_back({32'd2, 32'd14});
        present(OP_DIVU, 32'd100, 32'd7);
        tick();
        present(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
        run_busy(1'b1, busy, sbad, dn);
        check("t2_busy_cycles", busy, 32'd6);
        check("t2_stall_bad", sbad, 32'd0);
        check("t2_done_pulses", dn, 32'd1);
        @(negedge clk);
        check("t2_stall_idle", stall, 32'h0);
        tick();
        op_valid = 1'b0;
        check("t2_mthi_hi", hi, 32'hA5A5_A5A5);
        check("t2_mthi_lo", lo, 32'd14);

        // Engine never finishes: timeout after 64 WAIT cycles
        fin_delay = -1;
        present(OP_MULT, 32'd7, 32'd7);
        tick();
        op_valid = 1'b0;
        n = 0;
        bad = 0;
        while (n < 200) begin
            @(negedge clk);
            if (timeout_err === 1'b1) break;
            if (eng_bus.ena !== 1'b1) bad++;
            n++;
            tick();
        end
        check("t3_ena_cycles", n, 32'd65);
        check("t3_ena_gaps", bad, 32'd0);
        check("t3_drain_ena", eng_bus.ena, 32'h0);
        check("t3_hi", hi, 32'hA5A5_A5A5);
        check("t3_lo", lo, 32'd14);
        tick();
        @(negedge clk);
        check("t3_tmo_pulse", timeout_err, 32'h0);
        check("t3_ready", op_ready, 32'h1);
        tick();

        // MULTU 3*4 after the timeout
        fin_delay = 2;
        sb.push_back({32'd0, 32'd12});
        present(OP_MULTU, 32'd3, 32'd4);
        tick();
        op_valid = 1'b0;
        run_busy(1'b0, busy, sbad, dn);
        check("t3b_busy_cycles", busy, 32'd4);
        check("t3b_done_pulses", dn, 32'd1);
        check("t3b_hi", hi, 32'd0);
        check("t3b_lo", lo, 32'd12);

        // DIV flushed at WAIT cycle 3, engine would finish at cycle 5
        fin_delay = 5;
        present(OP_DIV, 32'hFFFF_FFEC, 32'd3);
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("t4_wait_ena", eng_bus.ena, 32'h1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t4_drain_ena", eng_bus.ena, 32'h0);
        check("t4_drain_done", done, 32'h0);
        tick();
        check("t4_ready", op_ready, 32'h1);
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
            tick();
        end
        check("t4_late_done", dn, 32'd0);
        check("t4_hi", hi, 32'd0);
        check("t4_lo", lo, 32'd12);

        // flush with MTLO in IDLE: nothing written
        present(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
        flush = 1'b1;
        tick();
        op_valid = 1'b0;
        flush = 1'b0;
        check("t4_flush_mtlo_lo", lo, 32'd12);
        check("t4_flush_mtlo_ena", eng_bus.ena, 32'h0);

        // Unknown op code is a no-op
        present(3'd7, 32'h1234_5678, 32'h1);
        tick();
        op_valid = 1'b0;
        check("unk_ready", op_ready, 32'h1);
        check("unk_ena", eng_bus.ena, 32'h0);
        check("unk_hi", hi, 32'd0);
        check("unk_lo", lo, 32'd12);

        // mf_req interlock during an operation
        fin_delay = 3;
        sb.push_back({32'd0, 32'd6});
        mf_req = 1'b1;
        present(OP_MULT, 32'd2, 32'd3);
        tick();
        op_valid = 1'b0;
        run_busy(1'b1, busy, sbad, dn);
        check("t5_busy_cycles", busy, 32'd5);
        check("t5_stall_bad", sbad, 32'd0);
        @(negedge clk);
        check("t5_stall_idle", stall, 32'h0);
        tick();
        mf_req = 1'b0;

        // Reset asserted mid-WAIT
        fin_delay = -1;
        present(OP_MULT, 32'd5, 32'd5);
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_hi", hi, 32'd0);
        check("t5_rst_lo", lo, 32'd0);
        check("t5_rst_ena", eng_bus.ena, 32'h0);
        check("t5_rst_ready", op_ready, 32'h1);
        check("t5_rst_done", done, 32'h0);

        // DIV by zero
        fin_delay = 2;
        sb.push_back({32'd9, 32'hFFFF_FFFF});
        present(OP_DIV, 32'd9, 32'd0);
        tick();
        op_valid = 1'b0;
`ifdef MDU_DIVZERO_BYPASS_EN
        check("t6_hi", hi, 32'd9);
        check("t6_lo", lo, 32'hFFFF_FFFF);
        check("t6_ready", op_ready, 32'h1);
        rose = 0;
        repeat (4) begin
            @(negedge clk);
            if (eng_bus.ena === 1'b1) rose++;
            tick();
        end
        check("t6_ena_rose", rose, 32'd0);
`else
        check("t6_ena", eng_bus.ena, 32'h1);
        run_busy(1'b0, busy, sbad, dn);
        check("t6_busy_cycles", busy, 32'd4);
        check("t6_done_pulses", dn, 32'd1);
        check("t6_hi", hi, 32'd9);
        check("t6_lo", lo, 32'hFFFF_FFFF);
`endif
        tick();
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
